bram2: RTL
==========

# bram2

Parametrised true-dual-port block-RAM behavioural model and mapping target, the next generation of the single-port test RAM used by the Xilinx BRAM mapping tests. Two independent read/write ports share one array. Each port has byte-lane write enables, a per-port read-during-write mode, an optional output pipeline register and a read-valid strobe. It serves as the golden model and synthesis input for the dual-port/byte-enable/OREG mapping rules.

## Interface
- ABITS, 8, address width; depth = 2**ABITS words
- DBITS, 16, data width; must be a multiple of BEBITS
- BEBITS, 2, byte lanes per word; lane width LW = DBITS/BEBITS
- RDMODE_A, 0, port A same-port read-during-write mode: 0 read-first, 1 write-first, 2 no-change
- RDMODE_B, 0, port B mode, same encoding as RDMODE_A
- OREG, 0, 1 adds one output register stage on both ports
- SRVAL, 0, DBITS-wide value loaded into RDATA by reset
- INIT_XOR, 0, initial content pattern: memory[a] = a XOR INIT_XOR, zero-extended or truncated to DBITS
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- A_EN  in  1  port A access enable
- A_WBE  in  BEBITS  port A byte-lane write enables; any bit set with A_EN makes the cycle a write
- A_ADDR  in  ABITS  port A address
- A_WDATA  in  DBITS  port A write data
- A_RDATA  out  DBITS  port A read data
- A_RVALID  out  1  high for exactly one cycle when A_RDATA holds a new read result
- B_EN, B_WBE, B_ADDR, B_WDATA, B_RDATA, B_RVALID: identical to port A

## Operation
- Array contents are set only by INIT_XOR at time zero. rst never clears the array.
- Port access occurs at a rising edge with EN=1 and rst=0. EN=0 leaves RDATA unchanged and RVALID low.
- Write: for each lane i with WBE[i]=1, memory[ADDR][i*LW +: LW] <= WDATA lane i. Disabled lanes keep their old contents.
- Every enabled cycle also reads, except no-change mode writes:
  - read-first: RDATA = word before the write
  - write-first: RDATA = word after the write (merged lanes)
  - no-change: on any write cycle RDATA holds and RVALID stays low; reads behave normally
- Cross-port read of an address written by the other port in the same cycle always returns the pre-write word.
- Both ports write the same address in the same cycle: lanes enabled on both take port B data. Lanes enabled on only one port take that port's data.
- Reset (asynchronous, takes effect immediately): RDATA <= SRVAL, RVALID <= 0, all OREG stages <= SRVAL/0.
  - While rst=1, writes are suppressed and no reads are issued.
  - Reads in flight at reset assertion are discarded and never produce RVALID.
- Address wrap: ADDR is exactly ABITS wide, so there is no out-of-range access. Address 2**ABITS-1 is legal.

## Timing
- Read latency from the EN edge to RDATA/RVALID is 1 cycle when OREG=0 and 2 cycles when OREG=1.
- RVALID is a pure pipeline of (EN & ~rst & ~(no-change & write)). Back-to-back reads give back-to-back RVALID with no bubbles.
- With OREG=1, an idle cycle after a read keeps the last valid data on RDATA, with RVALID low.
- Reset deassertion: the first access edge is the first edge with rst=0. Outputs stay at SRVAL/0 until the first result emerges.
- Ports are fully independent apart from the collision rules above. There are no stalls and no backpressure.

## Test plan
- Init/read: defaults, INIT_XOR=16'h00A5; read A addr 8'h03 -> A_RDATA=16'h00A6 with A_RVALID one cycle later. With OREG=1, the same values appear two cycles later.
- Byte enables: write A addr 8'h10, WBE=2'b01, WDATA=16'hBEEF over content 16'h00B5 -> a subsequent read returns 16'h00EF.
- RDW modes: addr 8'h20 holds 16'h0085. Write 16'h1234 with full WBE:
  - RDMODE_A=0 returns 16'h0085 on the write cycle
  - RDMODE_A=1 returns 16'h1234
  - RDMODE_A=2 holds the prior A_RDATA with A_RVALID=0
- Collision: same cycle, A writes 16'h1111 with WBE=2'b11 and B writes 16'h2222 with WBE=2'b01 to addr 8'h40 -> a later read gives 16'h1122.
- Cross-port: A writes 16'hCAFE to 8'h50 while B reads 8'h50 (content 16'h00F5) -> B_RDATA=16'h00F5; the next B read returns 16'hCAFE.
- Reset mid-read: SRVAL=16'hDEAD, OREG=1. Assert rst asynchronously between the issue and return of a read:
  - RDATA becomes 16'hDEAD immediately, RVALID=0, and the discarded read never validates
  - a write held with EN=1 during rst leaves memory unchanged
  - array contents survive reset

Source files
------------

// File: rtl/bram2_if.sv
// bram2_if: one port of the dual-port RAM (access request plus read return).
interface bram2_if #(
   parameter int ABITS  = 8,
   parameter int DBITS  = 16,
   parameter int BEBITS = 2
);
   logic              en;
   logic [BEBITS-1:0] wbe;
   logic [ABITS-1:0]  addr;
   logic [DBITS-1:0]  wdata;
   logic [DBITS-1:0]  rdata;
   logic              rvalid;

   modport master (output en, wbe, addr, wdata, input rdata, rvalid);
   modport slave  (input en, wbe, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/bram2.sv
// bram2: true-dual-port block RAM with byte-lane writes, per-port
// read-during-write mode, optional output register and read-valid strobe.
module bram2 #(
   parameter int               ABITS    = 8,
   parameter int               DBITS    = 16,
   parameter int               BEBITS   = 2,
   parameter int               RDMODE_A = 0,
   parameter int               RDMODE_B = 0,
   parameter int               OREG     = 0,
   parameter logic [DBITS-1:0] SRVAL    = '0,
   parameter int unsigned      INIT_XOR = 0
) (
   input logic    clk,
   input logic    rst,
   bram2_if.slave a_port,
   bram2_if.slave b_port
);
   localparam int DEPTH = 2 ** ABITS;
   localparam int LW    = DBITS / BEBITS;

   typedef enum logic [1:0] {
      READ_FIRST  = 2'd0,
      WRITE_FIRST = 2'd1,
      NO_CHANGE   = 2'd2
   } rdmode_e;

   // Index 0 is port A, index 1 is port B.
   logic [1:0]             en_p;
   logic [1:0][BEBITS-1:0] wbe_p;
   logic [1:0][ABITS-1:0]  addr_p;
   logic [1:0][DBITS-1:0]  wdata_p;
   logic [1:0][BEBITS-1:0] lane_we;
   logic [DBITS-1:0]       mem_rd  [DEPTH];
   logic [DBITS-1:0]       rdata_o [2];
   logic                   rvalid_o[2];

   assign en_p    = {b_port.en,    a_port.en};
   assign wbe_p   = {b_port.wbe,   a_port.wbe};
   assign addr_p  = {b_port.addr,  a_port.addr};
   assign wdata_p = {b_port.wdata, a_port.wdata};

   assign a_port.rdata  = rdata_o[0];
   assign a_port.rvalid = rvalid_o[0];
   assign b_port.rdata  = rdata_o[1];
   assign b_port.rvalid = rvalid_o[1];

   // Effective lane write strobes: nothing is written while reset is held.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      lane_we = '0;
      for (int p = 0; p < 2; p++) begin
         lane_we[p] = (en_p[p] && !rst) ? wbe_p[p] : '0;
      end
   end

   // Storage: one word register per address, seeded with the address XOR pattern.
   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      logic [DBITS-1:0] word_q = DBITS'(w ^ INIT_XOR);
      logic [DBITS-1:0] word_d;

      // Merge lane writes; port B is applied last so it wins lanes both ports write.
      always_comb begin
         word_d = word_q;
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < BEBITS; i++) begin
               // NOTE: blocking '=' here builds the merged word step by step; state updates below use '<='.
               if (lane_we[p][i] && (addr_p[p] == ABITS'(w))) begin
                  word_d[i*LW +: LW] = wdata_p[p][i*LW +: LW];
               end
            end
         end
      end

      // Word register update.
      always_ff @(posedge clk) begin
         // NOTE: the array has no reset on purpose; contents must survive rst and map onto block RAM.
         word_q <= word_d;
      end

      assign mem_rd[w] = word_q;
   end

   // Per-port read path and output pipeline.
   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam rdmode_e MODE = (p == 0) ? rdmode_e'(2'(RDMODE_A)) : rdmode_e'(2'(RDMODE_B));

      logic [DBITS-1:0] old_word;
      logic [DBITS-1:0] new_word;
      logic             issue;
      logic [DBITS-1:0] rdata1_d, rdata1_q, rdata2_d, rdata2_q;
      logic             rvalid1_d, rvalid1_q, rvalid2_d, rvalid2_q;

      // Choose the pre- or post-write word and decide whether this edge returns data.
      always_comb begin
         old_word = mem_rd[addr_p[p]];
         new_word = old_word;
         for (int i = 0; i < BEBITS; i++) begin
            if (lane_we[p][i]) begin
               new_word[i*LW +: LW] = wdata_p[p][i*LW +: LW];
            end
         end
         issue     = en_p[p] && !rst && !((MODE == NO_CHANGE) && (lane_we[p] != '0));
         rvalid1_d = issue;
         rdata1_d  = rdata1_q;
         if (issue) begin
            rdata1_d = (MODE == WRITE_FIRST) ? new_word : old_word;
         end
         // The output stage only reloads on a valid result, so idle cycles keep the last data.
         rvalid2_d = rvalid1_q;
         rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
      end

      // Read and output registers; reset discards anything in flight.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata1_q  <= SRVAL;
            rvalid1_q <= 1'b0;
            rdata2_q  <= SRVAL;
            rvalid2_q <= 1'b0;
         end else begin
            rdata1_q  <= rdata1_d;
            rvalid1_q <= rvalid1_d;
            rdata2_q  <= rdata2_d;
            rvalid2_q <= rvalid2_d;
         end
      end

      assign rdata_o[p]  = (OREG != 0) ? rdata2_q  : rdata1_q;
      assign rvalid_o[p] = (OREG != 0) ? rvalid2_q : rvalid1_q;
   end
endmodule
